// File: rtl/bus_cycle_ctrl_pkg.sv
// rtl/bus_cycle_ctrl_pkg.sv - shared FSM encodings, IACK function code and default chip-select map
package bus_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ACK  = 3'd2,
        ST_EXT  = 3'd3,
        ST_BERR = 3'd4
    } state_e;

    localparam logic [2:0] FC_IACK = 3'b111;

    // Default map: RAM on ch0, ROM with two waits on ch1, two device-terminated peripherals
    localparam int          DEF_NUM_CS   = 4;
    localparam int          DEF_ADDR_W   = 6;
    localparam int          DEF_WAIT_W   = 4;
    localparam int          DEF_TIMEOUT  = 64;
    localparam logic [23:0] DEF_CS_BASE  = {6'b111011, 6'b111010, 6'b001111, 6'b000000};
    localparam logic [23:0] DEF_CS_MASK  = {6'b111111, 6'b111111, 6'b001111, 6'b000111};
    localparam logic [15:0] DEF_CS_WAIT  = {4'd0, 4'd0, 4'd2, 4'd0};
    localparam logic [3:0]  DEF_CS_DTACK = 4'b0011;

endpackage

// File: rtl/bus_cycle_ctrl_cs_decoder.sv
// rtl/bus_cycle_ctrl_cs_decoder.sv - base/mask address compare with lowest-index priority
module bus_cycle_ctrl_cs_decoder
    import bus_cycle_ctrl_pkg::*;
#(
    parameter int                         NUM_CS  = DEF_NUM_CS,
    parameter int                         ADDR_W  = DEF_ADDR_W,
    parameter int                         CH_W    = 2,
    parameter logic [NUM_CS*ADDR_W-1:0]   CS_BASE = DEF_CS_BASE,
    parameter logic [NUM_CS*ADDR_W-1:0]   CS_MASK = DEF_CS_MASK
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NUM_CS-1:0] hit_o,
    output logic              any_hit_o,
    output logic [CH_W-1:0]   ch_o
);

    logic [ADDR_W-1:0] diff;

    always_comb begin
        hit_o     = '0;
        any_hit_o = 1'b0;
        ch_o      = '0;
        diff      = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            diff = (addr_i ^ CS_BASE[i*ADDR_W +: ADDR_W]) & CS_MASK[i*ADDR_W +: ADDR_W];
            if (diff == '0 && !any_hit_o) begin
                hit_o[i]  = 1'b1;
                any_hit_o = 1'b1;
                ch_o      = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// rtl/bus_cycle_ctrl.sv - 68000 bus-cycle controller: chip selects, wait states, DTACK, bus-error timeout
// Define BUS_CYCLE_CTRL_IACK_EN to decode IACK1..IACK7 during interrupt-acknowledge cycles.
module bus_cycle_ctrl
    import bus_cycle_ctrl_pkg::*;
#(
    parameter int                         NUM_CS   = DEF_NUM_CS,
    parameter int                         ADDR_W   = DEF_ADDR_W,
    parameter int                         WAIT_W   = DEF_WAIT_W,
    parameter logic [NUM_CS*ADDR_W-1:0]   CS_BASE  = DEF_CS_BASE,
    parameter logic [NUM_CS*ADDR_W-1:0]   CS_MASK  = DEF_CS_MASK,
    parameter logic [NUM_CS*WAIT_W-1:0]   CS_WAIT  = DEF_CS_WAIT,
    parameter logic [NUM_CS-1:0]          CS_DTACK = DEF_CS_DTACK,
    parameter int                         TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              por_n,
    input  logic              as_n,
    input  logic              rw,
    input  logic              lds_n,
    input  logic              uds_n,
    input  logic [2:0]        fc,
    input  logic [2:0]        addr_lower,
    input  logic [ADDR_W-1:0] addr_upper,
    output logic [NUM_CS-1:0] cs_n,
    output logic [6:0]        iack_n,
    output logic              lord_n,
    output logic              lowr_n,
    output logic              uprd_n,
    output logic              upwr_n,
    output logic              berr_n,
    inout  wire               dtack_n
);

    localparam int CH_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_EXPIRE = TMO_W'(TIMEOUT - 2);

    logic [NUM_CS-1:0] hit;
    logic              any_hit;
    logic [CH_W-1:0]   ch;
    logic              iack;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] count_q, count_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_step;
    logic              dtack_q, dtack_d;
    logic              berr_q, berr_d;

    assign iack = (fc == FC_IACK);

    bus_cycle_ctrl_cs_decoder #(
        .NUM_CS  (NUM_CS),
        .ADDR_W  (ADDR_W),
        .CH_W    (CH_W),
        .CS_BASE (CS_BASE),
        .CS_MASK (CS_MASK)
    ) u_cs_decoder (
        .addr_i    (addr_upper),
        .hit_o     (hit),
        .any_hit_o (any_hit),
        .ch_o      (ch)
    );

    assign cs_n   = ~hit | {NUM_CS{as_n | iack}};
    assign lowr_n = rw | lds_n;
    assign lord_n = ~rw | lds_n;
    assign upwr_n = rw | uds_n;
    assign uprd_n = ~rw | uds_n;

`ifdef BUS_CYCLE_CTRL_IACK_EN
    always_comb begin
        iack_n = 7'h7F;
        if (iack && !as_n && addr_lower != 3'd0)
            iack_n[addr_lower - 3'd1] = 1'b0;
    end
`else
    logic unused_addr_lower;
    assign unused_addr_lower = ^addr_lower;
    assign iack_n            = 7'h7F;
`endif

    always_ff @(posedge clk or negedge por_n) begin
        if (!por_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            tmo_q   <= '0;
            dtack_q <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tmo_q   <= tmo_d;
            dtack_q <= dtack_d;
            berr_q  <= berr_d;
        end
    end

    // Timeout counter saturates rather than wrapping
    assign tmo_step = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_IDLE: begin
                tmo_d   = '0;
                count_d = '0;
                if (!as_n) begin
                    if (any_hit && !iack && CS_DTACK[ch]) begin
                        count_d = CS_WAIT[int'(ch)*WAIT_W +: WAIT_W];
                        state_d = (count_d == '0) ? ST_ACK : ST_WAIT;
                    end else begin
                        state_d = ST_EXT;
                    end
                end
            end
            ST_WAIT: begin
                count_d = (count_q != '0) ? count_q - 1'b1 : '0;
                tmo_d   = tmo_step;
                if (count_q == WAIT_W'(1))
                    state_d = ST_ACK;
                else if (tmo_q == TMO_EXPIRE)
                    state_d = ST_BERR;
            end
            ST_EXT: begin
                // A device holding DTACK keeps the cycle here until the CPU ends it
                if (dtack_n !== 1'b0) begin
                    tmo_d = tmo_step;
                    if (tmo_q == TMO_EXPIRE)
                        state_d = ST_BERR;
                end
            end
            ST_ACK, ST_BERR: state_d = state_q;
            default:         state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && as_n)
            state_d = ST_IDLE;
    end

    always_comb begin
        dtack_d = (state_q == ST_ACK);
        berr_d  = (state_q == ST_BERR);
    end

    assign dtack_n = dtack_q ? 1'b0 : 1'bz;
    assign berr_n  = ~berr_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// tb/tb_bus_cycle_ctrl.sv - self-checking bench for bus_cycle_ctrl
module tb_bus_cycle_ctrl;

    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       por_n;
    logic       as_n, rw, lds_n, uds_n;
    logic [2:0] fc, addr_lower;
    logic [5:0] addr_upper;
    logic [3:0] cs_n;
    logic [6:0] iack_n;
    logic       lord_n, lowr_n, uprd_n, upwr_n, berr_n;
    logic       ext_dtack;
    wire        dtack_n;

    int tests = 0;
    int fails = 0;

    pullup (dtack_n);
    assign dtack_n = ext_dtack ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    bus_cycle_ctrl dut (
        .clk        (clk),
        .por_n      (por_n),
        .as_n       (as_n),
        .rw         (rw),
        .lds_n      (lds_n),
        .uds_n      (uds_n),
        .fc         (fc),
        .addr_lower (addr_lower),
        .addr_upper (addr_upper),
        .cs_n       (cs_n),
        .iack_n     (iack_n),
        .lord_n     (lord_n),
        .lowr_n     (lowr_n),
        .uprd_n     (uprd_n),
        .upwr_n     (upwr_n),
        .berr_n     (berr_n),
        .dtack_n    (dtack_n)
    );

    // Memory map as the system designer sees it
    logic [5:0] map_base [4] = '{6'h00, 6'h0F, 6'h3A, 6'h3B};
    logic [5:0] map_mask [4] = '{6'h07, 6'h0F, 6'h3F, 6'h3F};
    int         map_wait [4] = '{0, 2, 0, 0};
    bit         map_dtk  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    typedef struct {
        logic       as_n, rw, lds_n, uds_n;
        logic [2:0] fc, al;
        logic [5:0] au;
        logic [3:0] cs;
        logic [3:0] strb;
        logic [6:0] iack_en;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_ch(input logic [5:0] au);
        for (int i = 0; i < 4; i++)
            if (((au ^ map_base[i]) & map_mask[i]) == 6'h00) return i;
        return -1;
    endfunction

    function automatic logic [6:0] model_iack(input bit iack_cyc, input logic [2:0] al);
        logic [6:0] r = 7'h7F;
`ifdef BUS_CYCLE_CTRL_IACK_EN
        if (iack_cyc && al != 3'd0) r[int'(al) - 1] = 1'b0;
`endif
        return r;
    endfunction

    // One CPU cycle: as_n low for L sampled edges, optional device DTACK driven after check E.
    // Called and returns at a falling edge.
    task automatic run_txn(input logic [5:0] au, input logic [2:0] f, input logic [2:0] al,
                           input int len, input int ext_at);
        bit         iack_cyc = (f == 3'b111);
        int         ch       = iack_cyc ? -1 : model_ch(au);
        bit         gen      = (ch >= 0) && map_dtk[ch];
        int         w        = gen ? map_wait[ch] : 0;
        int         e        = gen ? -1 : ext_at;
        bit         berr_c;
        bit         exp_dt, exp_be;
        logic [3:0] exp_cs   = 4'hF;
        logic [6:0] exp_iack = model_iack(iack_cyc, al);
        logic [3:0] exp_strb;
        berr_c = !gen && len >= TIMEOUT && !(e >= 0 && e <= TIMEOUT - 2);
        if (ch >= 0) exp_cs[ch] = 1'b0;
        as_n       = 1'b0;
        addr_upper = au;
        fc         = f;
        addr_lower = al;
        rw         = 1'($urandom);
        lds_n      = 1'($urandom);
        uds_n      = 1'($urandom);
        exp_strb   = {~rw | lds_n, rw | lds_n, ~rw | uds_n, rw | uds_n};
        for (int n = 0; n <= len; n++) begin
            @(posedge clk);
            @(negedge clk);
            exp_dt = gen ? (w < len && n >= w + 1) : (e >= 0 && n >= e + 1 && n <= len - 1);
            exp_be = berr_c && n >= TIMEOUT;
            chk("dtack_n", 32'(dtack_n), 32'(!exp_dt));
            chk("berr_n", 32'(berr_n), 32'(!exp_be));
            chk("cs_n", 32'(cs_n), 32'((n < len) ? exp_cs : 4'hF));
            chk("iack_n", 32'(iack_n), 32'((n < len) ? exp_iack : 7'h7F));
            chk("strobes", 32'({lord_n, lowr_n, uprd_n, upwr_n}), 32'(exp_strb));
            if (n == e) ext_dtack = 1'b1;
            if (n == len - 1) begin
                as_n      = 1'b1;
                ext_dtack = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 3'd0, 6'h00, 4'b1111, 4'b0101, 7'h7F};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 3'd0, 6'h00, 4'b1110, 4'b0101, 7'h7F};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 3'd0, 6'h0F, 4'b1101, 4'b1011, 7'h7F};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 3'd2, 6'h3A, 4'b1011, 4'b1110, 7'h7F};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b101, 3'd0, 6'h3B, 4'b0111, 4'b1111, 7'h7F};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 3'd0, 6'h38, 4'b1110, 4'b0111, 7'h7F};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 3'd0, 6'h05, 4'b1111, 4'b0101, 7'h7F};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3'd5, 6'h00, 4'b1111, 4'b0101, 7'b1101111};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3'd0, 6'h0F, 4'b1111, 4'b0101, 7'h7F};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3'd1, 6'h00, 4'b1111, 4'b0101, 7'b1111110};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 3'd7, 6'h3A, 4'b1111, 4'b0101, 7'b0111111};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 3'd3, 6'h00, 4'b1111, 4'b0101, 7'h7F};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 3'd0, 6'h1F, 4'b1101, 4'b1111, 7'h7F};

        por_n = 1'b0; as_n = 1'b1; rw = 1'b1; lds_n = 1'b1; uds_n = 1'b1;
        fc = 3'b101; addr_lower = 3'd0; addr_upper = 6'h00; ext_dtack = 1'b0;

        // Combinational decode while held in reset, including as_n low
        foreach (vecs[i]) begin
            @(negedge clk);
            as_n = vecs[i].as_n; rw = vecs[i].rw; lds_n = vecs[i].lds_n; uds_n = vecs[i].uds_n;
            fc = vecs[i].fc; addr_lower = vecs[i].al; addr_upper = vecs[i].au;
            #2;
            chk($sformatf("vec%0d cs_n", i), 32'(cs_n), 32'(vecs[i].cs));
            chk($sformatf("vec%0d strobes", i), 32'({lord_n, lowr_n, uprd_n, upwr_n}), 32'(vecs[i].strb));
`ifdef BUS_CYCLE_CTRL_IACK_EN
            chk($sformatf("vec%0d iack_n", i), 32'(iack_n), 32'(vecs[i].iack_en));
`else
            chk($sformatf("vec%0d iack_n", i), 32'(iack_n), 32'h7F);
`endif
            chk($sformatf("vec%0d reset dtack_n", i), 32'(dtack_n), 32'h1);
            chk($sformatf("vec%0d reset berr_n", i), 32'(berr_n), 32'h1);
        end

        @(negedge clk);
        as_n = 1'b1;
        fc   = 3'b101;
        @(negedge clk);
        por_n = 1'b1;
        @(negedge clk);

        // Directed cycles
        run_txn(6'h00, 3'b101, 3'd0, 4, -1);
        run_txn(6'h0F, 3'b110, 3'd0, 5, -1);
        run_txn(6'h0F, 3'b110, 3'd0, 2, -1);
        run_txn(6'h0F, 3'b110, 3'd0, 3, -1);
        run_txn(6'h3A, 3'b101, 3'd0, 66, -1);
        run_txn(6'h3A, 3'b101, 3'd0, 8, 4);
        run_txn(6'h3A, 3'b101, 3'd0, TIMEOUT - 1, -1);
        run_txn(6'h3B, 3'b101, 3'd0, 66, TIMEOUT - 2);
        run_txn(6'h3B, 3'b101, 3'd0, 66, TIMEOUT - 1);
        run_txn(6'h00, 3'b111, 3'd5, 66, -1);
        run_txn(6'h0F, 3'b111, 3'd2, 6, 2);

        // Reset during an acknowledged cycle releases DTACK at once
        as_n = 1'b0; addr_upper = 6'h00; fc = 3'b101;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre-reset dtack_n", 32'(dtack_n), 32'h0);
        por_n = 1'b0;
        #1;
        chk("async reset dtack_n", 32'(dtack_n), 32'h1);
        as_n = 1'b1;
        @(negedge clk);
        por_n = 1'b1;
        @(negedge clk);
        chk("post-reset dtack_n", 32'(dtack_n), 32'h1);
        chk("post-reset berr_n", 32'(berr_n), 32'h1);

        // Randomized cycles against the map model
        for (int t = 0; t < 40; t++) begin
            logic [5:0] au;
            logic [2:0] f;
            int         len, e;
            case ($urandom_range(0, 4))
                0:       au = 6'h00;
                1:       au = 6'h0F;
                2:       au = 6'h3A;
                3:       au = 6'h3B;
                default: au = 6'($urandom);
            endcase
            f   = ($urandom_range(0, 5) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(58, 70)) : int'($urandom_range(1, 10));
            e   = -1;
            if (len >= 2 && $urandom_range(0, 1) == 1)
                e = (len > 60) ? int'($urandom_range(55, len - 2)) : int'($urandom_range(0, len - 2));
            run_txn(au, f, 3'($urandom), len, e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
